// File: rtl/cfg_reg_pkg.sv
// Shared address map and reset defaults for the system configuration register bank.
package cfg_reg_pkg;

  localparam int ADDR_ALU_A    = 0;
  localparam int ADDR_ALU_B    = 1;
  localparam int ADDR_ALU_CFG0 = 2;
  localparam int ADDR_ALU_CFG1 = 3;
  localparam int ADDR_UART_CFG = 4;
  localparam int ADDR_DIV      = 5;

  // UART: parity enable, prescale 32. Divider: divide by 32.
  localparam logic [7:0] UART_CFG_RST = 8'h81;
  localparam logic [7:0] DIV_RST      = 8'h20;

  // The UART and divider defaults only apply while those registers are exported;
  // otherwise the slot is plain storage that clears to zero.
  function automatic logic [63:0] reset_value(input int idx, input int num_cfg,
                                              input logic [63:0] uart_rst,
                                              input logic [63:0] div_rst);
    if (idx == ADDR_UART_CFG && idx < num_cfg) return uart_rst;
    if (idx == ADDR_DIV && idx < num_cfg) return div_rst;
    return '0;
  endfunction

endpackage

// File: rtl/cfg_reg_parity.sv
// Even-parity generator for write data and checker for read data of the register bank.
module cfg_reg_parity #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_par,
  output logic              wr_par,
  output logic              rd_bad
);

  assign wr_par = ^wr_data;
  assign rd_bad = (^rd_data) != rd_par;

endmodule

// File: rtl/cfg_reg_bank.sv
// Parametrised system register bank feeding ALU / UART / clock-divider configuration.
// Optional per-entry even parity is enabled with the CFG_REG_PARITY_EN macro.
module cfg_reg_bank #(
  parameter int                DATA_W       = 8,
  parameter int                ADDR_W       = 4,
  parameter int                DEPTH        = 16,
  parameter int                NUM_CFG      = 6,
  parameter logic [DATA_W-1:0] UART_CFG_RST = cfg_reg_pkg::UART_CFG_RST,
  parameter logic [DATA_W-1:0] DIV_RST      = cfg_reg_pkg::DIV_RST
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_W-1:0]         WrData,
  input  logic [ADDR_W-1:0]         Address,
  input  logic                      WrEn,
  input  logic                      RdEn,
`ifdef CFG_REG_PARITY_EN
  input  logic                      inj_par,
`endif
  output logic [DATA_W-1:0]         RdData,
  output logic                      RdData_Valid,
  output logic                      addr_err,
  output logic [NUM_CFG*DATA_W-1:0] cfg_bus,
  output logic [NUM_CFG-1:0]        cfg_upd,
  output logic                      par_err
);

  import cfg_reg_pkg::*;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  function automatic logic [DATA_W-1:0] rst_val(input int idx);
    logic [63:0] v;
    v = reset_value(idx, NUM_CFG, 64'(UART_CFG_RST), 64'(DIV_RST));
    return v[DATA_W-1:0];
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;
  logic              wr_hit;
  logic              rd_req;
  logic [DATA_W-1:0] rd_word;
  logic [NUM_CFG-1:0] upd_nxt;

  // Handshake: RdData_Valid is a one-cycle qualifier with no back-pressure; every
  // read request (in or out of range) yields exactly one pulse one cycle later.
  assign in_range = {1'b0, Address} < DEPTH_L;
  assign wr_hit   = WrEn && in_range;
  assign rd_req   = RdEn && !WrEn;

  always_comb begin
    rd_word = '0;
    if (in_range) rd_word = mem[Address];
  end

  always_comb begin
    upd_nxt = '0;
    for (int k = 0; k < NUM_CFG; k++) begin
      upd_nxt[k] = wr_hit && ({1'b0, Address} == (ADDR_W+1)'(k));
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= rst_val(i);
    end else if (wr_hit) begin
      mem[Address] <= WrData;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RdData       <= '0;
      RdData_Valid <= 1'b0;
      addr_err     <= 1'b0;
      cfg_upd      <= '0;
    end else begin
      RdData_Valid <= rd_req;
      if (rd_req) RdData <= rd_word;
      addr_err     <= (WrEn || RdEn) && !in_range;
      cfg_upd      <= upd_nxt;
    end
  end

  for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg
    assign cfg_bus[k*DATA_W +: DATA_W] = mem[k];
  end

`ifdef CFG_REG_PARITY_EN
  logic [DEPTH-1:0] par_mem;
  logic             rd_par;
  logic             wr_par;
  logic             rd_bad;

  always_comb begin
    rd_par = 1'b0;
    if (in_range) rd_par = par_mem[Address];
  end

  cfg_reg_parity #(.DATA_W(DATA_W)) u_parity (
    .wr_data (WrData),
    .rd_data (rd_word),
    .rd_par  (rd_par),
    .wr_par  (wr_par),
    .rd_bad  (rd_bad)
  );

  // inj_par corrupts the stored bit so the checker path can be exercised in test.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) par_mem[i] <= ^rst_val(i);
      par_err <= 1'b0;
    end else begin
      if (wr_hit) par_mem[Address] <= wr_par ^ inj_par;
      par_err <= rd_req && in_range && rd_bad;
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_reg_bank.sv
// Self-checking bench for cfg_reg_bank: a DEPTH=16 and a DEPTH=12 instance driven
// by directed and random accesses against an array-based reference model.
module tb_cfg_reg_bank;

`ifdef CFG_REG_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        CLK;
  logic        RST;
  logic [7:0]  wr_data  [2];
  logic [3:0]  addr     [2];
  logic        wr_en    [2];
  logic        rd_en    [2];
  logic        inj      [2];
  logic [7:0]  rd_data  [2];
  logic        rd_valid [2];
  logic        addr_err [2];
  logic        par_err  [2];
  logic [47:0] cfg_bus  [2];
  logic [5:0]  cfg_upd  [2];

  // reference model
  logic [7:0] ref_mem [2][16];
  bit         ref_bad [2][16];
  logic [7:0] last_rd [2];
  logic [7:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  cfg_reg_bank #(.DEPTH(16)) u_dut16 (
    .CLK(CLK), .RST(RST), .WrData(wr_data[0]), .Address(addr[0]),
    .WrEn(wr_en[0]), .RdEn(rd_en[0]),
`ifdef CFG_REG_PARITY_EN
    .inj_par(inj[0]),
`endif
    .RdData(rd_data[0]), .RdData_Valid(rd_valid[0]), .addr_err(addr_err[0]),
    .cfg_bus(cfg_bus[0]), .cfg_upd(cfg_upd[0]), .par_err(par_err[0])
  );

  cfg_reg_bank #(.DEPTH(12)) u_dut12 (
    .CLK(CLK), .RST(RST), .WrData(wr_data[1]), .Address(addr[1]),
    .WrEn(wr_en[1]), .RdEn(rd_en[1]),
`ifdef CFG_REG_PARITY_EN
    .inj_par(inj[1]),
`endif
    .RdData(rd_data[1]), .RdData_Valid(rd_valid[1]), .addr_err(addr_err[1]),
    .cfg_bus(cfg_bus[1]), .cfg_upd(cfg_upd[1]), .par_err(par_err[1])
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] pack_cfg(input int s);
    logic [47:0] p;
    for (int k = 0; k < 6; k++) p[k*8 +: 8] = ref_mem[s][k];
    return p;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) begin
        ref_mem[s][i] = 8'h00;
        ref_bad[s][i] = 1'b0;
      end
      ref_mem[s][4] = 8'h81;
      ref_mem[s][5] = 8'h20;
      last_rd[s] = 8'h00;
    end
    exp_q.delete();
  endtask

  task automatic check_reset_state();
    for (int s = 0; s < 2; s++) begin
      check_eq("rst_rd_data", 64'(rd_data[s]), 64'(8'h00));
      check_eq("rst_rd_valid", 64'(rd_valid[s]), 64'(1'b0));
      check_eq("rst_addr_err", 64'(addr_err[s]), 64'(1'b0));
      check_eq("rst_cfg_upd", 64'(cfg_upd[s]), 64'(6'h00));
      check_eq("rst_par_err", 64'(par_err[s]), 64'(1'b0));
      check_eq("rst_cfg_bus", 64'(cfg_bus[s]), 64'(pack_cfg(s)));
    end
  endtask

  // driver: one access on instance s, then checks every output one cycle later
  task automatic access(input int s, input bit we, input bit re, input logic [3:0] a,
                        input logic [7:0] d, input bit ij);
    int         dep;
    bit         in_rng, exp_v, exp_err, exp_par;
    logic [5:0] exp_upd;
    dep     = (s == 0) ? 16 : 12;
    in_rng  = int'(a) < dep;
    exp_v   = re && !we;
    exp_err = (we || re) && !in_rng;
    exp_par = exp_v && in_rng && ref_bad[s][a];
    exp_upd = (we && in_rng && a < 4'd6) ? (6'd1 << a) : 6'd0;
    if (exp_v) exp_q.push_back(in_rng ? ref_mem[s][a] : 8'h00);
    if (we && in_rng) begin
      ref_mem[s][a] = d;
      ref_bad[s][a] = ij && PAR_EN;
    end
    wr_en[s] = we; rd_en[s] = re; addr[s] = a; wr_data[s] = d; inj[s] = ij;
    @(posedge CLK);
    #1;
    wr_en[s] = 1'b0; rd_en[s] = 1'b0; inj[s] = 1'b0;
    check_eq("rd_valid", 64'(rd_valid[s]), 64'(exp_v));
    if (exp_v && exp_q.size() > 0) last_rd[s] = exp_q.pop_front();
    check_eq("rd_data", 64'(rd_data[s]), 64'(last_rd[s]));
    check_eq("addr_err", 64'(addr_err[s]), 64'(exp_err));
    check_eq("cfg_upd", 64'(cfg_upd[s]), 64'(exp_upd));
    check_eq("cfg_bus", 64'(cfg_bus[s]), 64'(pack_cfg(s)));
    check_eq("par_err", 64'(par_err[s]), 64'(exp_par));
  endtask

  initial begin
    int op;
    int s;
    for (int i = 0; i < 2; i++) begin
      wr_data[i] = '0; addr[i] = '0; wr_en[i] = 1'b0; rd_en[i] = 1'b0; inj[i] = 1'b0;
    end
    RST = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_reset_state();
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check_reset_state();
    @(negedge CLK);

    // reset contents of every address
    for (int a = 0; a < 16; a++) access(0, 1'b0, 1'b1, 4'(a), 8'h00, 1'b0);
    check_eq("cfg_bus_uart", 64'(cfg_bus[0][39:32]), 64'(8'h81));
    check_eq("cfg_bus_div", 64'(cfg_bus[0][47:40]), 64'(8'h20));

    // write then read-back-to-back
    access(0, 1'b1, 1'b0, 4'd2, 8'hA5, 1'b0);
    access(0, 1'b0, 1'b1, 4'd2, 8'h00, 1'b0);
    check_eq("cfg_bus_alu_cfg0", 64'(cfg_bus[0][23:16]), 64'(8'hA5));

    // simultaneous write and read: write wins, no valid
    access(0, 1'b1, 1'b1, 4'd7, 8'h3C, 1'b0);
    access(0, 1'b0, 1'b1, 4'd7, 8'h00, 1'b0);

    // out-of-range on DEPTH=12
    access(1, 1'b1, 1'b0, 4'd13, 8'hFF, 1'b0);
    access(1, 1'b0, 1'b1, 4'd13, 8'h00, 1'b0);
    access(1, 1'b0, 1'b1, 4'd11, 8'h00, 1'b0);
    access(1, 1'b0, 1'b1, 4'd12, 8'h00, 1'b0);

`ifdef CFG_REG_PARITY_EN
    access(0, 1'b1, 1'b0, 4'd3, 8'h07, 1'b1);
    access(0, 1'b0, 1'b1, 4'd3, 8'h00, 1'b0);
    access(0, 1'b1, 1'b0, 4'd3, 8'h07, 1'b0);
    access(0, 1'b0, 1'b1, 4'd3, 8'h00, 1'b0);
`endif

    // asynchronous reset in the middle of a pending read
    access(0, 1'b1, 1'b0, 4'd4, 8'h11, 1'b0);
    rd_en[0] = 1'b1; addr[0] = 4'd4;
    #3;
    RST = 1'b0;
    #1;
    model_reset();
    check_reset_state();
    @(posedge CLK);
    #1;
    check_eq("rst_no_valid", 64'(rd_valid[0]), 64'(1'b0));
    rd_en[0] = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    access(0, 1'b0, 1'b1, 4'd4, 8'h00, 1'b0);

    // random traffic on both instances
    for (int i = 0; i < 400; i++) begin
      s  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 9));
      access(s, op <= 3 || op == 9, op >= 4, 4'($urandom_range(0, 15)),
             8'($urandom_range(0, 255)), PAR_EN && ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
